// File: rtl/softmax_sched_pkg.sv
// softmax_sched_pkg
//   Shared definitions for the softmax row scheduler: length-mode
//   encodings, the drain FSM state type, the default row width and a
//   small helper that classifies a length mode.
package softmax_sched_pkg;

  localparam logic [1:0] MODE_16      = 2'd0;
  localparam logic [1:0] MODE_32      = 2'd1;
  localparam logic [1:0] MODE_64      = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int DATA_W_DEF = 1024;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A row is only issued when its length mode is one the datapath supports.
  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode != MODE_ILLEGAL);
  endfunction

endpackage

// File: rtl/softmax_sched_if.sv
// softmax_sched_if
//   Requester-side bundle of the scheduler.
//   i_req_valid/i_req_data/i_req_mode : per-requester rows (master drives)
//   o_req_ready                       : one-hot grant (slave drives)
//   o_res_valid/o_res_id/o_res_prob   : routed result, no backpressure
//   master = requester side, slave = scheduler side.
interface softmax_sched_if
  import softmax_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ*2-1:0]      i_req_mode;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_res_valid;
  logic [ID_W-1:0]           o_res_id;
  logic [DATA_W-1:0]         o_res_prob;

  modport master (
    output i_req_valid, i_req_data, i_req_mode,
    input  o_req_ready, o_res_valid, o_res_id, o_res_prob
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_mode,
    output o_req_ready, o_res_valid, o_res_id, o_res_prob
  );

endinterface

// File: rtl/softmax_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker.
//   req      : request vector
//   en       : grant enable; when low no grant is produced
//   ptr      : highest-priority requester this cycle
//   grant    : one-hot grant or all zero
//   grant_id : index of the granted requester (ptr when none)
//   next_ptr : winner+1 with wrap, or ptr when nothing was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [ID_W-1:0]    next_ptr
);

  logic            found_s;
  logic [ID_W-1:0] idx_s;

  // Search upward from ptr with wrap; the first active request wins.
  always_comb begin
    grant    = '0;
    grant_id = ptr;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_id     = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end else begin
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/softmax_sched.sv
// softmax_sched
//   Shares one softmax_approx datapath among NUM_REQ row requesters.
//   Rows are granted round-robin, issued one per cycle with a one-cycle
//   register stage, and each issued row's requester ID is queued in an
//   order FIFO so the in-order datapath results can be routed back.
//   In-flight rows are credit-limited to MAX_INFLIGHT; i_flush drains.
//   Ports:
//     i_clk, i_rst_n          : clock, synchronous active-low reset
//     req_if (slave)          : requester rows, one-hot ready, results
//     o_sm_en/o_sm_valid/o_sm_length_mode/o_sm_in_x_flat : datapath in
//     i_sm_valid/i_sm_prob_flat                          : datapath out
//     i_flush/o_flush_done    : drain request level / drained pulse
//     o_busy                  : rows in flight
//     o_err                   : sticky illegal-mode / orphan-result flag
module softmax_sched
  import softmax_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_INFLIGHT = 16,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  softmax_sched_if.slave    req_if,
  output logic              o_sm_en,
  output logic              o_sm_valid,
  output logic [1:0]        o_sm_length_mode,
  output logic [DATA_W-1:0] o_sm_in_x_flat,
  input  logic              i_sm_valid,
  input  logic [DATA_W-1:0] i_sm_prob_flat,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  state_t             state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [ID_W-1:0]    fifo_r [MAX_INFLIGHT];

  logic               grant_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic               hs_s;
  logic [1:0]         sel_mode_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               issue_s;
  logic               illegal_s;
  logic               pop_s;
  logic               orphan_s;

  // No grant in the cycle a flush is first seen, nor while out of credit.
  // Reset also holds ready low so no handshake can complete during it.
  assign grant_en_s = i_rst_n && (state_r == ST_RUN) && !i_flush &&
                      (cnt_r < CNT_W'(MAX_INFLIGHT));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_if.i_req_valid),
    .en       (grant_en_s),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .grant_id (grant_id_s),
    .next_ptr (next_ptr_s)
  );

  assign req_if.o_req_ready = grant_s;
  assign hs_s      = |(req_if.i_req_valid & grant_s);
  assign issue_s   = hs_s && mode_legal(sel_mode_s);
  assign illegal_s = hs_s && !mode_legal(sel_mode_s);
  // The credit count equals FIFO occupancy, so it doubles as the empty flag.
  assign pop_s     = i_sm_valid && (cnt_r != '0);
  assign orphan_s  = i_sm_valid && (cnt_r == '0);

  // Select the granted requester's row and mode.
  always_comb begin
    sel_data_s = '0;
    sel_mode_s = MODE_16;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        sel_data_s = req_if.i_req_data[k*DATA_W +: DATA_W];
        sel_mode_s = req_if.i_req_mode[k*2 +: 2];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next in-flight count; issue and result together cancel out.
  always_comb begin
    case ({issue_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_next_s = cnt_r - CNT_W'(1);
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Drain FSM with registered done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= ST_RUN;
      o_flush_done <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          o_flush_done <= 1'b0;
          state_r      <= i_flush ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: begin
          if (cnt_r == '0) begin
            state_r      <= ST_DONE;
            o_flush_done <= 1'b1;
          end else begin
            state_r      <= ST_DRAIN;
            o_flush_done <= 1'b0;
          end
        end
        ST_DONE: begin
          o_flush_done <= 1'b0;
          state_r      <= i_flush ? ST_DRAIN : ST_RUN;
        end
        default: begin
          o_flush_done <= 1'b0;
          state_r      <= ST_RUN;
        end
      endcase
    end
  end

  // Arbitration pointer, credits, FIFO pointers, busy and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_r    <= '0;
      cnt_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      o_busy   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      ptr_r    <= next_ptr_s;
      cnt_r    <= cnt_next_s;
      wr_ptr_r <= issue_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      o_busy   <= (cnt_next_s != '0);
      o_err    <= o_err | orphan_s | illegal_s;
    end
  end

  // Order FIFO storage; contents are meaningless until written.
  always_ff @(posedge i_clk) begin
    if (issue_s) begin
      fifo_r[wr_ptr_r] <= grant_id_s;
    end else begin
      fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
    end
  end

  // Datapath issue stage, one cycle behind the handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sm_en          <= 1'b0;
      o_sm_valid       <= 1'b0;
      o_sm_length_mode <= MODE_16;
      o_sm_in_x_flat   <= '0;
    end else begin
      o_sm_en    <= 1'b1;
      o_sm_valid <= issue_s;
      if (issue_s) begin
        o_sm_length_mode <= sel_mode_s;
        o_sm_in_x_flat   <= sel_data_s;
      end else begin
        o_sm_length_mode <= o_sm_length_mode;
        o_sm_in_x_flat   <= o_sm_in_x_flat;
      end
    end
  end

  // Result routing: tag popped alongside the datapath output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_if.o_res_valid <= 1'b0;
      req_if.o_res_id    <= '0;
      req_if.o_res_prob  <= '0;
    end else begin
      req_if.o_res_valid <= pop_s;
      if (pop_s) begin
        req_if.o_res_id   <= fifo_r[rd_ptr_r];
        req_if.o_res_prob <= i_sm_prob_flat;
      end else begin
        req_if.o_res_id   <= req_if.o_res_id;
        req_if.o_res_prob <= req_if.o_res_prob;
      end
    end
  end

endmodule
